// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline stage.
// Bundles stay flat vectors so any CTRL_W/DATA_W works.
package pipe_pkg;

    localparam int MAX_STAGES = 8;

    // Bubble control value, wide enough for any CTRL_W; cast down at use.
    localparam logic [63:0] CTRL_BUBBLE = '0;

    // Occupancy counts 0..2*stages (main + skid per slot).
    function automatic int cnt_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready bundle carrying one control word and one data word.
// A transfer happens on a rising edge where valid && ready; while valid=1
// and ready=0 the master holds valid, ctrl and data stable.
interface pipe_stage_elastic_if #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 69
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, ctrl, data, input ready);
    modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_skid_slot.sv
// One elastic slot: a main register feeding downstream plus a one-entry
// skid register, so in_ready depends only on local state.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 69
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic load_main;

    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    // Main can take a new word when empty or when its word leaves this edge.
    assign load_main = !main_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= CTRL_W'(CTRL_BUBBLE);
            skid_valid <= 1'b0;
            skid_ctrl  <= CTRL_W'(CTRL_BUBBLE);
        end else if (load_main) begin
            if (skid_valid) begin
                // in_ready was low, so no new word can collide with this move.
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_ctrl  <= CTRL_W'(CTRL_BUBBLE);
            end else if (accept) begin
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
                main_ctrl  <= CTRL_W'(CTRL_BUBBLE);
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: STAGES chained skid slots (legal 1..8) with
// synchronous flush and an occupancy count of valid entries.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 69,
    parameter int STAGES = 1,
    parameter int CNT_W  = cnt_width(STAGES)
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_elastic_if.slave  in_bus,
    pipe_stage_elastic_if.master out_bus,
    input  logic                 flush,
    output logic [CNT_W-1:0]     occupancy
);
    logic              chain_valid [STAGES+1];
    logic              chain_ready [STAGES+1];
    logic [CTRL_W-1:0] chain_ctrl  [STAGES+1];
    logic [DATA_W-1:0] chain_data  [STAGES+1];
    logic [1:0]        slot_count  [STAGES];
    logic [CNT_W-1:0]  occ_sum;

    assign chain_valid[0]      = in_bus.valid;
    assign chain_ctrl[0]       = in_bus.ctrl;
    assign chain_data[0]       = in_bus.data;
    assign in_bus.ready        = chain_ready[0];
    assign out_bus.valid       = chain_valid[STAGES];
    assign out_bus.ctrl        = chain_ctrl[STAGES];
    assign out_bus.data        = chain_data[STAGES];
    assign chain_ready[STAGES] = out_bus.ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        pipe_skid_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (chain_valid[k]),
            .in_ready  (chain_ready[k]),
            .in_ctrl   (chain_ctrl[k]),
            .in_data   (chain_data[k]),
            .out_valid (chain_valid[k+1]),
            .out_ready (chain_ready[k+1]),
            .out_ctrl  (chain_ctrl[k+1]),
            .out_data  (chain_data[k+1]),
            .count     (slot_count[k])
        );
    end

    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_sum = occ_sum + CNT_W'(slot_count[k]);
        end
    end

    assign occupancy = occ_sum;

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic pipeline-stage register that replaces the fixed EX/MEM-style latch. It moves a control bundle and a data bundle through STAGES register slots using a valid/ready handshake, so the stage can stall without losing data. Each slot has a one-entry skid buffer, so in_ready is fully registered. It also supports a synchronous flush that turns every in-flight entry into a bubble. It sits between any two processor pipeline stages (EX->MEM, MEM->WB).

Parameters:
CTRL_W, 3, width of control bundle (e.g. RegWrite, MemtoReg, MemWrite)
DATA_W, 69, width of data bundle (e.g. AluOut 32 + WriteData 32 + WriteReg 5)
STAGES, 1, number of chained slots; legal range 1..8
CNT_W, $clog2(2*STAGES+1), width of the occupancy counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream has an entry
in_ready  out  1  block can accept; registered
in_ctrl  in  CTRL_W  control bundle from upstream
in_data  in  DATA_W  data bundle from upstream
out_valid  out  1  head entry is valid
out_ready  in  1  downstream accepts the head entry
out_ctrl  out  CTRL_W  head control bundle; all-zero whenever out_valid=0
out_data  out  DATA_W  head data bundle
flush  in  1  synchronous kill of all in-flight entries
occupancy  out  CNT_W  number of valid entries held (0..2*STAGES)

Behaviour:
- Reset (rst=0, async): every slot main_valid=0 and skid_valid=0; all ctrl and data registers are 0. Outputs: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0. Release is synchronous to clk; the first accept can happen on the first rising edge after release.
- Handshake: a transfer occurs on an edge where valid&ready=1. in_valid/in_ctrl/in_data must stay stable while in_valid=1 and in_ready=0. The block does the same on its output side.
- Per-slot operation (slot k, input from slot k-1 or the ports; output to slot k+1 or the ports):
  - slot_in_ready = !skid_valid (registered).
  - Accept with main empty, or with main draining this cycle: the word goes to main.
  - Accept with main full and not draining: the word goes to skid, and slot_in_ready drops on the next edge.
  - Main drains while skid is full: skid moves to main the same edge and skid_valid clears. A new input cannot arrive in that cycle, because ready was 0.
- Latency: 1 cycle per slot. An entry accepted at edge n appears on out_* after edge n+STAGES-1+1 = n+STAGES if it meets no stalls.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Bubble: whenever a slot is not valid, its ctrl register is written to 0, so a bubble carries no side-effecting control. Data of an invalid slot holds its old value and is don't-care, except it is 0 after reset.
- Flush (sync, highest priority over the edge's handshake):
  - All main_valid and skid_valid clear and all ctrl registers go to 0.
  - The in_* word presented in the flush cycle is discarded, even if in_ready=1.
  - A downstream accept in the flush cycle still counts as delivered; the head is already committed.
  - After the edge: in_ready=1 and occupancy=0.
- occupancy: the sum of all main_valid and skid_valid bits, updated every edge; it is 2*STAGES when full. The bench checks it as an invariant.
- Simultaneous accept and drain on a full head slot: net occupancy is unchanged and ordering is strictly FIFO.
- Reset asserted mid-operation: all state is lost immediately (async); no partial transfer completes.

Decomposition:
- Shared package pipe_pkg holds localparam helpers (CNT_W computation) and a bubble constant CTRL_BUBBLE = '0 for ctrl. No struct typedefs: the bundles stay flat vectors so they work for any CTRL_W/DATA_W.
- One natural sub-module, pipe_skid_slot (main+skid registers, valid/ready logic, flush), instantiated STAGES times in a generate loop.
- The top level only chains the slots and computes occupancy.

Test Plan:
- Reset then stream, STAGES=1: in_valid=1 with ctrl=3'b101, data=69'h1_DEAD_BEEF_0000_1234 for 4 back-to-back words, out_ready=1 -> each word appears on out_* exactly 1 cycle after acceptance; in_ready stays 1; occupancy peaks at 1.
- Back-pressure, STAGES=2: out_ready=0 while 5 words are offered -> 4 accepted (occupancy=4), then in_ready=0. Set out_ready=1 -> words emerge in order 0..3, then the 5th follows with no loss and no duplicate.
- Skid path, STAGES=1: out_ready drops on the same cycle as the second accept -> the second word sits in skid and in_ready=0 next cycle. When out_ready returns, words 1 and 2 emerge on consecutive cycles.
- Flush, STAGES=3: 6 entries held, flush=1 together with in_valid=1 (ctrl=3'b111) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the flush-cycle word never appears.
- Bubble control: with in_valid=0 for 3 cycles while the pipe drains -> out_ctrl=3'b000 on every cycle where out_valid=0.
- Async reset mid-stream: assert rst=0 between edges with occupancy=3 -> outputs go to 0 immediately and in_ready=1. After release, the first new word appears with the normal latency.
